// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA adapter write port shared by several draw engines.
// The granted engine's pixel stream is forwarded combinationally while the arbiter is in DRAW.
module vga_draw_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20000,
  parameter int CW      = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   finish,
  input  logic [NREQ-1:0]   plot_in,
  input  logic [8*NREQ-1:0] x_in,
  input  logic [7*NREQ-1:0] y_in,
  input  logic [3*NREQ-1:0] colour_in,
  output logic [NREQ-1:0]   start,
  output logic [NREQ-1:0]   grant,
  output logic              plot,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DRAW, S_RELEASE} state_t;

  state_t          state_q;
  logic [IW-1:0]   g_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   wd_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] start_q;
  logic            terr_q;

  logic [IW-1:0]   pick_d;
  logic            pick_vld_d;
  logic            fin_sel;
  logic            plot_sel;
  logic [7:0]      x_sel;
  logic [6:0]      y_sel;
  logic [2:0]      c_sel;
  logic            draw;

  // Round-robin scan starts just past the last engine served.
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    pick_vld_d = 1'b0;
    pick_d     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (!pick_vld_d && req[idx]) begin
        pick_vld_d = 1'b1;
        pick_d     = idx;
      end
    end
  end

  always_comb begin
    fin_sel  = 1'b0;
    plot_sel = 1'b0;
    x_sel    = '0;
    y_sel    = '0;
    c_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_q == IW'(i)) begin
        fin_sel  = finish[i];
        plot_sel = plot_in[i];
        x_sel    = x_in[8*i +: 8];
        y_sel    = y_in[7*i +: 7];
        c_sel    = colour_in[3*i +: 3];
      end
    end
  end

  // Handshake: an engine holds req (level); the arbiter answers with a one-cycle
  // start pulse; the engine ends its grant with a one-cycle finish pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      last_q  <= IW'(NREQ-1);
      wd_q    <= '0;
      grant_q <= '0;
      start_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= '0;
      terr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            g_q     <= pick_d;
            grant_q <= NREQ'(1) << pick_d;
            start_q <= NREQ'(1) << pick_d;
            state_q <= S_START;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          wd_q <= wd_q + CW'(1);
          if (fin_sel) begin
            grant_q <= '0;
            state_q <= S_RELEASE;
          end else if (wd_q == CW'(TIMEOUT-1)) begin
            grant_q <= '0;
            terr_q  <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          last_q  <= g_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign draw        = (state_q == S_DRAW);
  assign plot        = draw & plot_sel;
  assign x           = draw ? x_sel : '0;
  assign y           = draw ? y_sel : '0;
  assign colour      = draw ? c_sel : '0;
  assign start       = start_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: engines are modelled by driver tasks and
// every forwarded pixel is matched against a queue of expected {x,y,colour}.
module tb_vga_draw_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   finish = '0;
  logic [NREQ-1:0]   plot_in = '0;
  logic [8*NREQ-1:0] x_in = '0;
  logic [7*NREQ-1:0] y_in = '0;
  logic [3*NREQ-1:0] colour_in = '0;
  logic [NREQ-1:0]   start;
  logic [NREQ-1:0]   grant;
  logic              plot;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              busy;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  vga_draw_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .CW(16)) dut (
    .clock(clock), .resetn(resetn), .req(req), .finish(finish),
    .plot_in(plot_in), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .start(start), .grant(grant), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every plot strobe must match the oldest expected pixel
  always @(negedge clock) begin
    if (resetn === 1'b1 && plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_plot", {x, y, colour}, 18'h0);
      end else begin
        chk("pixel", {x, y, colour}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic set_eng(input int e, input logic p, input logic [7:0] xx,
                         input logic [6:0] yy, input logic [2:0] cc, input logic f);
    plot_in[e]           = p;
    x_in[8*e +: 8]       = xx;
    y_in[7*e +: 7]       = yy;
    colour_in[3*e +: 3]  = cc;
    finish[e]            = f;
  endtask

  task automatic clr_eng();
    finish = '0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
  endtask

  task automatic wait_start(input int e);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (start !== '0) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
    start_cyc = cyc;
    chk("start_onehot", 32'(start), 32'(NREQ'(1) << e));
    chk("grant_start", 32'(grant), 32'(NREQ'(1) << e));
    chk("busy_start", 32'(busy), 32'd1);
    chk("plot_start", 32'(plot), 32'd0);
  endtask

  task automatic run_engine(input int e, input int ndraw, input bit fin,
                            input bit plot_last, input bit noise, input bit exp_terr);
    logic       p;
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;
    wait_start(e);
    for (int k = 0; k < ndraw; k++) begin
      @(posedge clock); #1;
      p  = (k < ndraw-1) ? 1'b1 : plot_last;
      xx = 8'($urandom_range(0, 255));
      yy = 7'($urandom_range(0, 119));
      cc = 3'($urandom_range(0, 7));
      set_eng(e, p, xx, yy, cc, fin && (k == ndraw-1));
      if (noise) begin
        for (int j = 0; j < NREQ; j++)
          if (j != e) set_eng(j, 1'b1, 8'd99, 7'd5, 3'd7, 1'b1);
      end
      if (p) exp_q.push_back({xx, yy, cc});
      @(negedge clock);
      chk("grant_draw", 32'(grant), 32'(NREQ'(1) << e));
      chk("start_draw", 32'(start), 32'd0);
      chk("terr_draw", 32'(timeout_err), 32'd0);
    end
    @(posedge clock); #1;
    clr_eng();
    @(negedge clock);
    chk("grant_rel", 32'(grant), 32'd0);
    chk("plot_rel", {plot, x, y, colour}, 32'd0);
    chk("busy_rel", 32'(busy), 32'd1);
    chk("terr_rel", 32'(timeout_err), 32'(exp_terr));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_check();
    @(posedge clock); #1;
    @(negedge clock);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("grant_idle", 32'(grant), 32'd0);
    chk("terr_idle", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int c0;
    int prev;
    // reset values, with engines driving garbage
    plot_in = '1; x_in = '1; y_in = '1; colour_in = '1; req = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pixel", {plot, x, y, colour}, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    clr_eng();
    @(posedge clock); #1;
    resetn = 1'b1;

    // single requester; req drops during START and is ignored
    @(posedge clock); #1;
    req = 4'b0001;
    c0 = cyc;
    @(posedge clock); #1;
    req = 4'b0000;
    run_engine(0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_latency", 32'(start_cyc), 32'(c0 + 1));
    idle_check();
    idle_check();

    // round robin from a fresh reset: 0,1,2,3,0
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_engine(i % NREQ, 5, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (i > 0) chk("rr_gap", 32'(start_cyc - prev), 32'd8);
      prev = start_cyc;
    end
    req = 4'b0000;
    idle_check();

    // isolation: other engines plot x=99 and pulse finish while engine 2 owns the port
    req = 4'b0100;
    run_engine(2, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    idle_check();

    // watchdog: engine 1 never finishes, engine 2 waits and is next
    req = 4'b0110;
    run_engine(1, TO, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_check();
    // finish on the timeout cycle wins
    run_engine(2, TO, 1'b1, 1'b1, 1'b0, 1'b0);
    req = 4'b0000;
    idle_check();

    // async reset mid-DRAW on engine 3
    req = 4'b1000;
    wait_start(3);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      set_eng(3, 1'b1, 8'(10 + k), 7'(20 + k), 3'(k + 1), 1'b0);
      exp_q.push_back({8'(10 + k), 7'(20 + k), 3'(k + 1)});
      @(negedge clock);
    end
    @(posedge clock); #1;
    set_eng(3, 1'b1, 8'd77, 7'd66, 3'd5, 1'b0);
    #1;
    chk("plot_pre_rst", {plot, x, y, colour}, {1'b1, 8'd77, 7'd66, 3'd5});
    resetn = 1'b0;
    #1;
    chk("async_plot", 32'(plot), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("queue_pre_rst", 32'(exp_q.size()), 32'd0);
    clr_eng();
    req = 4'b1111;
    @(posedge clock); #1;
    resetn = 1'b1;
    run_engine(0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0000;
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
